// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller.
//   RESET_PC       : first fetch address after reset; PC reported on bubbles
//   INST_SIZE_WORD : encoding of a 32-bit access on the instruction port
//   fetch_state_e  : fetch FSM state
package if_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC       = 32'hbfc00000;
  localparam logic [1:0]  INST_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,  // address phase outstanding
    ST_WAIT   = 2'd1,  // address accepted, waiting for data
    ST_HOLD   = 2'd2,  // fetched instruction parked while ID is stalled
    ST_CANCEL = 2'd3   // waiting to drain a response that will be dropped
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_ctrl_hold.sv
// One-entry instruction/PC skid register used when ID stalls on a response.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   load            : capture load_inst/load_pc, entry becomes valid
//   consume, flush  : retire the entry (ID took it / redirect dropped it)
//   valid, inst, pc : stored entry
module if_hold_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        consume,
  input  logic        flush,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      inst  <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= load_inst;
      pc    <= load_pc;
    end else if (consume || flush) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch initiator for an SRAM-like instruction port. Owns the
// fetch PC, keeps at most one read outstanding and hands instruction/PC
// pairs to ID, marking bubbles with IF_invalid.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   inst_req/wr/size/addr      : request address phase (read-only, word)
//   inst_addr_ok/data_ok/rdata : port handshakes and read data
//   ID_stall                   : ID cannot take an instruction this cycle
//   redirect_valid/pc          : restart fetch at a new target
//   IF_invalid/inst/pc         : instruction offered to ID
// Optional build macro IF_FETCH_PERF_EN adds saturating counters
//   perf_cancel_cnt (discarded fetches) and perf_stall_cnt (stalled HOLD cycles).
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = if_fetch_ctrl_pkg::RESET_PC,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        ID_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef IF_FETCH_PERF_EN
  output logic [31:0] perf_cancel_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  output logic        IF_invalid,
  output logic [31:0] IF_inst,
  output logic [31:0] IF_pc
);

  fetch_state_e state, state_nxt;
  logic [31:0]  fetch_pc, fetch_nxt;
  logic         pend_v, pend_v_nxt;     // redirect waiting for the port to drain
  logic [31:0]  pend_pc, pend_pc_nxt;
  logic         offer, discard;
  logic [31:0]  off_inst, off_pc;
  logic         hold_load, hold_consume, hold_flush, hold_valid;
  logic [31:0]  hold_inst, hold_pc;

  if_hold_reg u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_load),
    .consume   (hold_consume),
    .flush     (hold_flush),
    .load_inst (inst_rdata),
    .load_pc   (fetch_pc),
    .valid     (hold_valid),
    .inst      (hold_inst),
    .pc        (hold_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_REQ;
      fetch_pc <= RESET_PC;
      pend_v   <= 1'b0;
      pend_pc  <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_nxt;
      pend_v   <= pend_v_nxt;
      pend_pc  <= pend_pc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_nxt    = fetch_pc;
    pend_v_nxt   = pend_v;
    pend_pc_nxt  = pend_pc;
    offer        = 1'b0;
    off_inst     = '0;
    off_pc       = RESET_PC;
    hold_load    = 1'b0;
    hold_consume = 1'b0;
    hold_flush   = 1'b0;
    discard      = 1'b0;
    case (state)
      ST_REQ: begin
        if (inst_addr_ok) begin
          // A redirect seen now or earlier poisons the request just accepted.
          if (redirect_valid || pend_v) begin
            state_nxt  = ST_CANCEL;
            pend_v_nxt = 1'b1;
            discard    = 1'b1;
            if (redirect_valid) pend_pc_nxt = redirect_pc;
          end else begin
            state_nxt = ST_WAIT;
          end
        end else if (redirect_valid) begin
          pend_v_nxt  = 1'b1;
          pend_pc_nxt = redirect_pc;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          discard = 1'b1;
          if (inst_data_ok) begin
            // Response drained this cycle, so restart immediately.
            state_nxt = ST_REQ;
            fetch_nxt = redirect_pc;
          end else begin
            state_nxt   = ST_CANCEL;
            pend_v_nxt  = 1'b1;
            pend_pc_nxt = redirect_pc;
          end
        end else if (inst_data_ok) begin
          offer    = 1'b1;
          off_inst = inst_rdata;
          off_pc   = fetch_pc;
          if (ID_stall) begin
            hold_load = 1'b1;
            state_nxt = ST_HOLD;
          end else begin
            fetch_nxt = fetch_pc + PC_STEP;
            state_nxt = ST_REQ;
          end
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          hold_flush = 1'b1;
          discard    = 1'b1;
          fetch_nxt  = redirect_pc;
          state_nxt  = ST_REQ;
        end else begin
          offer    = hold_valid;
          off_inst = hold_inst;
          off_pc   = hold_pc;
          if (!ID_stall) begin
            hold_consume = 1'b1;
            fetch_nxt    = fetch_pc + PC_STEP;
            state_nxt    = ST_REQ;
          end
        end
      end
      ST_CANCEL: begin
        if (redirect_valid) pend_pc_nxt = redirect_pc;
        if (inst_data_ok) begin
          fetch_nxt  = redirect_valid ? redirect_pc : pend_pc;
          pend_v_nxt = 1'b0;
          state_nxt  = ST_REQ;
        end
      end
      default: state_nxt = ST_REQ;
    endcase
  end

  // Gating on rst keeps the port quiet and ID fed bubbles while reset is held.
  assign inst_req   = (state == ST_REQ) && !rst;
  assign inst_wr    = 1'b0;
  assign inst_size  = INST_SIZE_WORD;
  assign inst_addr  = fetch_pc;
  assign IF_invalid = rst || !offer;
  assign IF_inst    = IF_invalid ? 32'd0 : off_inst;
  assign IF_pc      = IF_invalid ? RESET_PC : off_pc;

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cancel_cnt <= '0;
      perf_stall_cnt  <= '0;
    end else begin
      if (discard && (perf_cancel_cnt != '1))
        perf_cancel_cnt <= perf_cancel_cnt + 32'd1;
      if ((state == ST_HOLD) && ID_stall && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed, table-driven bench for if_fetch_ctrl. Inputs are applied on the
// falling edge and outputs compared 1ns later, before the next rising edge.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        ID_stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        IF_invalid;
  logic [31:0] IF_inst, IF_pc;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_cancel_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  if_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .inst_req       (inst_req),
    .inst_wr        (inst_wr),
    .inst_size      (inst_size),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .ID_stall       (ID_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef IF_FETCH_PERF_EN
    .perf_cancel_cnt(perf_cancel_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .IF_invalid     (IF_invalid),
    .IF_inst        (IF_inst),
    .IF_pc          (IF_pc)
  );

  typedef struct {
    logic        rst, aok, dok;
    logic [31:0] rdata;
    logic        stall, rv;
    logic [31:0] rpc;
    logic        ereq;
    logic [31:0] eaddr;
    logic        einv;
    logic [31:0] einst, epc;
    logic        chk_if;   // 0: IF_* outputs not compared on this row
  } vec_t;

  localparam logic [31:0] RP = 32'hbfc00000;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, a, d, input logic [31:0] rd, input logic s, v, input logic [31:0] p);
    rst = r; inst_addr_ok = a; inst_data_ok = d; inst_rdata = rd;
    ID_stall = s; redirect_valid = v; redirect_pc = p;
  endtask

  initial begin
    vec_t v;
    bit   seen;
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    //            rst aok dok rdata         stl rv rpc           req addr          inv inst          pc            chk
    // reset state, then back-to-back fetches
    vq.push_back('{1, 0, 0, 32'h0,        0, 0, 32'h0,        0, RP,            1, 32'h0,        RP,           1});
    vq.push_back('{0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00000,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 0, 1, 32'h11111111, 0, 0, 32'h0,        0, 32'hbfc00000,  0, 32'h11111111, 32'hbfc00000, 1});
    vq.push_back('{0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00004,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 0, 1, 32'h22222222, 0, 0, 32'h0,        0, 32'hbfc00004,  0, 32'h22222222, 32'hbfc00004, 1});
    vq.push_back('{0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00008,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 0, 1, 32'h33333333, 0, 0, 32'h0,        0, 32'hbfc00008,  0, 32'h33333333, 32'hbfc00008, 1});
    vq.push_back('{0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc0000c,  1, 32'h0,        RP,           1});
    // reset while in WAIT; late data_ok afterwards is ignored
    vq.push_back('{1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hbfc0000c,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 0, 1, 32'hdeadbeef, 0, 0, 32'h0,        1, 32'hbfc00000,  1, 32'h0,        RP,           1});
    // ID stall for 3 cycles around a returned instruction
    vq.push_back('{0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00000,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 0, 1, 32'h24020001, 1, 0, 32'h0,        0, 32'hbfc00000,  0, 32'h24020001, 32'hbfc00000, 1});
    vq.push_back('{0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'hbfc00000,  0, 32'h24020001, 32'hbfc00000, 1});
    vq.push_back('{0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'hbfc00000,  0, 32'h24020001, 32'hbfc00000, 1});
    vq.push_back('{0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hbfc00000,  0, 32'h24020001, 32'hbfc00000, 1});
    // addr_ok delayed 4 cycles: request and address stay put
    vq.push_back('{0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00004,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00004,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00004,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00004,  1, 32'h0,        RP,           1});
    // redirect in WAIT together with data_ok: data dropped, restart at target
    vq.push_back('{0, 0, 1, 32'h55555555, 0, 1, 32'hbfc00100, 0, 32'hbfc00004,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00100,  1, 32'h0,        RP,           1});
    // redirect in WAIT before data: CANCEL drains the response
    vq.push_back('{0, 0, 0, 32'h0,        0, 1, 32'hbfc00180, 0, 32'hbfc00100,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 0, 1, 32'h66666666, 0, 0, 32'h0,        0, 32'hbfc00100,  1, 32'h0,        RP,           1});
    // redirect before addr_ok, then a second one in CANCEL: last one wins
    vq.push_back('{0, 0, 0, 32'h0,        0, 1, 32'hbfc00140, 1, 32'hbfc00180,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00180,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 0, 0, 32'h0,        0, 1, 32'hbfc00200, 0, 32'hbfc00180,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 0, 1, 32'h77777777, 0, 0, 32'h0,        0, 32'hbfc00180,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00200,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 0, 1, 32'h88888888, 0, 0, 32'h0,        0, 32'hbfc00200,  0, 32'h88888888, 32'hbfc00200, 1});
    // redirect while holding: entry dropped, restart at target
    vq.push_back('{0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00204,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 0, 1, 32'h99999999, 1, 0, 32'h0,        0, 32'hbfc00204,  0, 32'h99999999, 32'hbfc00204, 1});
    vq.push_back('{0, 0, 0, 32'h0,        1, 1, 32'hbfc00300, 0, 32'hbfc00204,  1, 32'h0,        RP,           0});
    // PC wrap from fffffffc to 0
    vq.push_back('{0, 1, 0, 32'h0,        0, 1, 32'hfffffffc, 1, 32'hbfc00300,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 0, 1, 32'h0,        0, 0, 32'h0,        0, 32'hbfc00300,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hfffffffc,  1, 32'h0,        RP,           1});
    vq.push_back('{0, 0, 1, 32'haaaaaaaa, 0, 0, 32'h0,        0, 32'hfffffffc,  0, 32'haaaaaaaa, 32'hfffffffc, 1});
    vq.push_back('{0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h00000000,  1, 32'h0,        RP,           1});

    foreach (vq[i]) begin
      v = vq[i];
      @(negedge clk);
      drive(v.rst, v.aok, v.dok, v.rdata, v.stall, v.rv, v.rpc);
      #1;
      chk("inst_req",  i, {31'd0, inst_req}, {31'd0, v.ereq});
      chk("inst_addr", i, inst_addr, v.eaddr);
      chk("inst_ctl",  i, {29'd0, inst_wr, inst_size}, 32'd2);
      if (v.chk_if) begin
        chk("IF_invalid", i, {31'd0, IF_invalid}, {31'd0, v.einv});
        chk("IF_inst",    i, IF_inst, v.einst);
        chk("IF_pc",      i, IF_pc, v.epc);
      end
    end

`ifdef IF_FETCH_PERF_EN
    // discards: WAIT+data redirect, WAIT->CANCEL, REQ->CANCEL twice, HOLD drop
    chk("perf_cancel_cnt", -1, perf_cancel_cnt, 32'd5);
    chk("perf_stall_cnt",  -1, perf_stall_cnt,  32'd3);
`endif

    // Hand-written: reset release with a bounded wait for the first request,
    // then a 1-cycle-latency data phase.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    seen = 0;
    for (int c = 0; c < 4 && !seen; c++) begin
      #1;
      if (inst_req) seen = 1;
      else @(negedge clk);
    end
    chk("req_after_reset", -2, {31'd0, seen}, 32'd1);
    chk("first_addr", -2, inst_addr, RP);
    drive(0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 1, 32'h12345678, 0, 0, 0);
    #1;
    chk("first_inst", -2, IF_inst, 32'h12345678);
    chk("first_pc",   -2, IF_pc, RP);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("second_addr", -2, inst_addr, 32'hbfc00004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
